// File: rtl/dual_issue_hazard_ctrl.sv
// Issue/stall scheduler for the dual-lane pipeline: sequences the decode pair and resolves hazards that in-lane forwarding cannot cover.
// Latency: control outputs are combinational from the current inputs and state; the RUN/SPLIT state advances on each rising clk edge.
// Backpressure: memReady=0 freezes E/M/W and stalls F/D; branchFlush takes effect only once memReady=1.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   validD*, rs/rtD*, useRtD*   decode pair sources
//   regWriteD*, writeRegD*      decode pair destinations
//   *E1/*E2, *M1/*M2            execute / memory stage destinations per lane
//   branchFlush, memReady       redirect and data-memory handshake
//   stallF, stallD, flushD      F/D controls
//   flushE1, flushE2            per-lane D/E bubble insertion
//   freezeEMW                   hold D/E, E/M, M/W during a memory wait
//   splitActive                 slot 1 issued, slot 2 still pending in D
//   stallCycles, splitCycles,   statistics counters; present only when
//   memWaitCycles               HAZARD_STATS_EN is defined, else tied to 0
module dual_issue_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             validD1,
   input  logic             validD2,
   input  logic [REG_W-1:0] rsD1,
   input  logic [REG_W-1:0] rtD1,
   input  logic [REG_W-1:0] rsD2,
   input  logic [REG_W-1:0] rtD2,
   input  logic             useRtD1,
   input  logic             useRtD2,
   input  logic             regWriteD1,
   input  logic             regWriteD2,
   input  logic [REG_W-1:0] writeRegD1,
   input  logic [REG_W-1:0] writeRegD2,
   input  logic             regWriteE1,
   input  logic             regWriteE2,
   input  logic             memToRegE1,
   input  logic             memToRegE2,
   input  logic [REG_W-1:0] writeRegE1,
   input  logic [REG_W-1:0] writeRegE2,
   input  logic             regWriteM1,
   input  logic             regWriteM2,
   input  logic [REG_W-1:0] writeRegM1,
   input  logic [REG_W-1:0] writeRegM2,
   input  logic             branchFlush,
   input  logic             memReady,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE1,
   output logic             flushE2,
   output logic             freezeEMW,
   output logic             splitActive,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] splitCycles,
   output logic [CNT_W-1:0] memWaitCycles
);

   typedef enum logic {RUN, SPLIT} state_t;

   state_t state;
   state_t nextState;

   // Register 0 is hardwired, so it never produces a dependency.
   function automatic logic regMatch(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic             we);
      return we && (dst != '0) && (src == dst);
   endfunction

   // rs is always a source; rt only when the instruction actually reads it.
   function automatic logic srcHit(input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             useRt,
                                   input logic [REG_W-1:0] dst,
                                   input logic             we);
      return regMatch(rs, dst, we) || (useRt && regMatch(rt, dst, we));
   endfunction

   logic lu1, lu2, x1, x2, intra, hazard1, hazard2;

   always_comb begin
      // Load-use within a lane: the load result is not forwardable from E.
      lu1 = validD1 && memToRegE1 &&
            srcHit(rsD1, rtD1, useRtD1, writeRegE1, regWriteE1);
      lu2 = validD2 && memToRegE2 &&
            srcHit(rsD2, rtD2, useRtD2, writeRegE2, regWriteE2);
      // Cross-lane RAW: no forwarding path exists between lanes. W is
      // covered by the write-through register file.
      x1  = validD1 &&
            (srcHit(rsD1, rtD1, useRtD1, writeRegE2, regWriteE2) ||
             srcHit(rsD1, rtD1, useRtD1, writeRegM2, regWriteM2));
      x2  = validD2 &&
            (srcHit(rsD2, rtD2, useRtD2, writeRegE1, regWriteE1) ||
             srcHit(rsD2, rtD2, useRtD2, writeRegM1, regWriteM1));
      // Intra-pair RAW or WAW: slot 2 must trail slot 1 by a cycle.
      intra = validD1 && validD2 && regWriteD1 && (writeRegD1 != '0) &&
              (srcHit(rsD2, rtD2, useRtD2, writeRegD1, 1'b1) ||
               (regWriteD2 && (writeRegD2 == writeRegD1)));
      hazard1 = lu1 || x1;
      hazard2 = lu2 || x2;
   end

   always_comb begin
      stallF      = 1'b0;
      stallD      = 1'b0;
      flushD      = 1'b0;
      flushE1     = 1'b0;
      flushE2     = 1'b0;
      freezeEMW   = 1'b0;
      splitActive = 1'b0;
      nextState   = state;
      if (reset) begin
         nextState = RUN;
      end else begin
         splitActive = (state == SPLIT);
         if (!memReady) begin
            // The branch source holds branchFlush across the wait.
            freezeEMW = 1'b1;
            stallF    = 1'b1;
            stallD    = 1'b1;
         end else if (branchFlush) begin
            flushD    = 1'b1;
            nextState = RUN;
         end else if (state == RUN) begin
            if (hazard1) begin
               // Slot-1 stall wins even if slot 2 also has a hazard.
               stallF  = 1'b1;
               stallD  = 1'b1;
               flushE1 = 1'b1;
               flushE2 = 1'b1;
            end else if (hazard2 || intra) begin
               stallF    = 1'b1;
               stallD    = 1'b1;
               flushE2   = 1'b1;
               nextState = SPLIT;
            end
         end else begin
            // Slot 1 already issued; only slot 2's dependencies matter.
            if (hazard2) begin
               stallF  = 1'b1;
               stallD  = 1'b1;
               flushE1 = 1'b1;
               flushE2 = 1'b1;
            end else begin
               flushE1   = 1'b1;
               nextState = RUN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= nextState;
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles   <= '0;
         splitCycles   <= '0;
         memWaitCycles <= '0;
      end else begin
         if (stallD && memReady) stallCycles   <= stallCycles + 1'b1;
         if (state == SPLIT)     splitCycles   <= splitCycles + 1'b1;
         if (!memReady)          memWaitCycles <= memWaitCycles + 1'b1;
      end
   end
`else
   assign stallCycles   = '0;
   assign splitCycles   = '0;
   assign memWaitCycles = '0;
`endif

endmodule

// File: doc/dual_issue_hazard_ctrl.md
Name: dual_issue_hazard_ctrl

Overview:
Issue/stall scheduler for the dual-lane pipeline. Forwarding is per-lane only (M/W of lane k to E of lane k). This block sequences the decode pair into both lanes and resolves the hazards that in-lane forwarding cannot cover:
- same-lane load-use
- cross-lane RAW
- intra-pair dependencies, by split issue
- memory wait freezes

It drives the F/D stall and the D/E flush controls of both lanes.

Parameters:
REG_W, 5, register specifier width
CNT_W, 32, width of statistics counters (optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
validD1, validD2  in  1  decode slot holds a real instruction
rsD1, rtD1, rsD2, rtD2  in  REG_W  decode source registers
useRtD1, useRtD2  in  1  rt is a source operand (not a destination)
regWriteD1, regWriteD2  in  1  decode instruction writes a register
writeRegD1, writeRegD2  in  REG_W  decode destination
regWriteE1, regWriteE2, memToRegE1, memToRegE2  in  1  execute-stage write and load flags
writeRegE1, writeRegE2  in  REG_W  execute-stage destination
regWriteM1, regWriteM2  in  1  memory-stage write flag
writeRegM1, writeRegM2  in  REG_W  memory-stage destination
branchFlush  in  1  taken branch or jump resolved; discard the decode pair
memReady  in  1  data memory can complete this cycle
stallF, stallD  out  1  hold the PC and the F/D register
flushD  out  1  clear the F/D register
flushE1, flushE2  out  1  insert a bubble into the D/E register of lane 1 / lane 2
freezeEMW  out  1  hold the D/E, E/M and M/W registers
splitActive  out  1  state == SPLIT
stallCycles, splitCycles, memWaitCycles  out  CNT_W  statistics counters

Behaviour:
- State register: RUN (reset value) or SPLIT (slot 1 already issued, slot 2 pending in D).
- Outputs are combinational from the current inputs and state. Next state is registered.
- Reset: state = RUN and counters = 0 on the next edge. While reset = 1, all 1-bit outputs are forced to 0. Reset during SPLIT discards the pending slot 2.
- match(src, dst, we): true when we = 1, dst != 0 and src == dst.
- A source is checked only if it is used: rs always; rt only when useRt = 1.
- A hazard on a slot is raised only when that slot's valid bit is 1.
- LU1: a slot-1 source matches writeRegE1 with memToRegE1 = 1. LU2: the same check for slot 2 against lane 2.
- X1: a slot-1 source matches E2 or M2. X2: a slot-2 source matches E1 or M1. The register file is write-through, so the W stage is never a hazard.
- INTRA: requires validD1, validD2 and regWriteD1 with writeRegD1 != 0. It is true when a slot-2 source matches writeRegD1, or when regWriteD2 = 1 and writeRegD2 == writeRegD1 (WAW).
- Priority, highest first: reset, then memReady = 0, then branchFlush, then hazards.
- memReady = 0: freezeEMW = stallF = stallD = 1, no flushes, state holds. branchFlush is ignored in this cycle; the source holds it until memReady = 1.
- branchFlush = 1: flushD = 1, stallF = stallD = 0, flushE1 = flushE2 = 0, next state = RUN. This cancels SPLIT.
- RUN with LU1 or X1: stallF = stallD = flushE1 = flushE2 = 1, stay in RUN.
- RUN, otherwise, with LU2, X2 or INTRA: stallF = stallD = flushE2 = 1, flushE1 = 0 (slot 1 issues), next state = SPLIT.
- RUN with no hazard: all outputs 0, both slots issue.
- SPLIT: validD1 and INTRA are ignored.
  - LU2 or X2: stallF = stallD = flushE1 = flushE2 = 1, stay in SPLIT.
  - Otherwise: flushE1 = 1, stallF = stallD = 0 (slot 2 issues alone), next state = RUN.
- Register 0 never creates a hazard.
- Simultaneous hazards on both slots in RUN are resolved as an LU1/X1 stall; no split occurs that cycle.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: the counters increment by 1 per cycle, wrap at 2^CNT_W, and are cleared by reset.
  - stallCycles: cycles with stallD = 1 and memReady = 1.
  - splitCycles: cycles with state == SPLIT.
  - memWaitCycles: cycles with memReady = 0.
- Undefined: the counter outputs are tied to 0 and no counter flops are present.

Test Plan:
- Load-use, lane 1: E1 is lw to $8 (memToRegE1 = 1); D1 is add with rs = $8 -> one cycle of stallF = stallD = flushE1 = flushE2 = 1; both slots issue the next cycle.
- Intra-pair RAW: D1 writes $5; D2 reads rs = $5 -> cycle 0: flushE2 = 1 and state goes to SPLIT. Cycles 1-2: X2 stalls (E1, then M1 = $5). Cycle 3: flushE1 = 1, stall = 0, state returns to RUN.
- Register 0 and rt not used: D2 reads rt = $5 with useRtD2 = 0, and D1 writes $0 with D2 reading $0 -> no stall, no flush.
- Branch during SPLIT: branchFlush = 1 -> flushD = 1, no stalls, next state = RUN; splitActive = 0 next cycle.
- Memory wait: memReady = 0 for 3 cycles during an LU1 stall -> freezeEMW = stallF = stallD = 1, no flush, state held. With HAZARD_STATS_EN, memWaitCycles = 3.
- Reset asserted in SPLIT with a cross-lane hazard present -> all outputs 0 during reset; state = RUN and counters = 0 after the edge.
